// File: rtl/perf_counter_dump_engine.sv
// perf_counter_dump_engine
// Snapshots NUM_COUNTERS counters on pc_start, packs them CPB-per-beat into
// AXI write beats and writes them as a single burst into a ring of DDR slots.
//
// Handshake rule for every channel: a transfer happens on a rising edge where
// valid and ready are both high. While valid is high and ready is low, the
// valid, data, address and last outputs hold their values. All valids are
// decoded from the registered state, so no ready input reaches a valid output
// combinationally.
module perf_counter_dump_engine #(
   parameter int PC_DATA_WIDTH  = 64,
   parameter int AXI_DATA_WIDTH = 256,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int NUM_COUNTERS   = 24,
   parameter int NUM_SLOTS      = 4,
   localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   pc_start,
   input  logic [NUM_COUNTERS*PC_DATA_WIDTH-1:0]  pc_counters,
   input  logic [AXI_ADDR_WIDTH-1:0]              base_addr,
   input  logic                                   slot_clear,
   output logic [AXI_ADDR_WIDTH-1:0]              axi_aw_addr,
   output logic [7:0]                             axi_aw_len,
   output logic                                   axi_aw_valid,
   input  logic                                   axi_aw_ready,
   output logic [AXI_DATA_WIDTH-1:0]              axi_w_data,
   output logic                                   axi_w_last,
   output logic                                   axi_w_valid,
   input  logic                                   axi_w_ready,
   input  logic                                   axi_b_valid,
   input  logic [1:0]                             axi_b_resp,
   output logic                                   axi_b_ready,
   output logic                                   pc_busy,
   output logic                                   pc_done,
   output logic                                   pc_err,
   output logic [SLOT_W-1:0]                      slot_idx,
   output logic [2:0]                             o_dbg_state
);

   localparam int CPB    = AXI_DATA_WIDTH / PC_DATA_WIDTH;
   localparam int BEATS  = (NUM_COUNTERS + CPB - 1) / CPB;
   localparam int SNAP_W = NUM_COUNTERS * PC_DATA_WIDTH;
   localparam int PACK_W = BEATS * AXI_DATA_WIDTH;
   localparam logic [AXI_ADDR_WIDTH-1:0] STRIDE = AXI_ADDR_WIDTH'(BEATS * (AXI_DATA_WIDTH / 8));
   localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AW   = 3'd1,
      S_W    = 3'd2,
      S_B    = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                    r_state;
   state_t                    w_next;
   logic [SNAP_W-1:0]         r_snap;
   logic [7:0]                r_beat;
   logic [AXI_ADDR_WIDTH-1:0] r_aw_addr;
   logic [SLOT_W-1:0]         r_slot;
   logic                      r_err;
   logic [SLOT_W-1:0]         w_slot_eff;
   logic [PACK_W-1:0]         w_pack;
   logic                      w_start;
   logic                      w_is_last;
   logic                      w_beat_hs;

   // A start is only honoured in IDLE; slot_clear wins over the stored index
   // so a simultaneous clear+start targets slot 0.
   assign w_start    = (r_state == S_IDLE) && pc_start;
   assign w_slot_eff = slot_clear ? '0 : r_slot;
   assign w_is_last  = (r_beat == LAST_BEAT);
   assign w_beat_hs  = (r_state == S_W) && axi_w_ready;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (pc_start)                 w_next = S_AW;
         S_AW:    if (axi_aw_ready)             w_next = S_W;
         S_W:     if (axi_w_ready && w_is_last) w_next = S_B;
         S_B:     if (axi_b_valid)              w_next = S_DONE;
         S_DONE:                                w_next = S_IDLE;
         default:                               w_next = S_IDLE;
      endcase
   end

   // Outputs decoded from the registered state
   always_comb begin
      axi_aw_valid = 1'b0;
      axi_w_valid  = 1'b0;
      axi_w_last   = 1'b0;
      axi_b_ready  = 1'b0;
      pc_done      = 1'b0;
      pc_busy      = 1'b1;
      case (r_state)
         S_IDLE:  pc_busy = 1'b0;
         S_AW:    axi_aw_valid = 1'b1;
         S_W: begin
            axi_w_valid = 1'b1;
            axi_w_last  = w_is_last;
         end
         S_B:     axi_b_ready = 1'b1;
         S_DONE:  pc_done = 1'b1;
         default: pc_busy = 1'b0;
      endcase
   end

   // Capture the counter snapshot and the burst address when a dump starts
   always_ff @(posedge clk) begin
      if (reset) begin
         r_snap    <= '0;
         r_aw_addr <= '0;
      end else if (w_start) begin
         r_snap    <= pc_counters;
         r_aw_addr <= base_addr + AXI_ADDR_WIDTH'(w_slot_eff) * STRIDE;
      end
   end

   // Beat counter: cleared on start, advanced per accepted beat, parked on the
   // last beat so the data mux never indexes past the packed record
   always_ff @(posedge clk) begin
      if (reset)                        r_beat <= 8'd0;
      else if (w_start)                 r_beat <= 8'd0;
      else if (w_beat_hs && !w_is_last) r_beat <= r_beat + 8'd1;
   end

   // Ring index: advances once per completed dump, cleared on request in IDLE
   always_ff @(posedge clk) begin
      if (reset)
         r_slot <= '0;
      else if (r_state == S_DONE)
         r_slot <= (r_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : r_slot + SLOT_W'(1);
      else if ((r_state == S_IDLE) && slot_clear)
         r_slot <= '0;
   end

   // Sticky error flag for any non-OKAY write response
   always_ff @(posedge clk) begin
      if (reset)
         r_err <= 1'b0;
      else if ((r_state == S_B) && axi_b_valid && (axi_b_resp != 2'b00))
         r_err <= 1'b1;
   end

   // Zero-pad the snapshot to whole beats; counter k lands in beat k/CPB,
   // lane k%CPB, because CPB counters exactly fill one beat
   always_comb begin
      w_pack              = '0;
      w_pack[SNAP_W-1:0]  = r_snap;
   end

   assign axi_w_data  = w_pack[int'(r_beat) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
   assign axi_aw_addr = r_aw_addr;
   assign axi_aw_len  = LAST_BEAT;
   assign pc_err      = r_err;
   assign slot_idx    = r_slot;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_perf_counter_dump_engine.sv
// Bench for perf_counter_dump_engine: default build (24 x 64-bit counters,
// 256-bit beats) plus a narrow build (5 counters, 128-bit beats).
module tb_perf_counter_dump_engine;

  int vectors = 0;
  int miscompares = 0;
  int m_slot = 0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Default instance
  logic           pc_start, slot_clear, aw_ready, w_ready, b_valid;
  logic [1535:0]  pc_counters;
  logic [63:0]    base_addr, aw_addr;
  logic [1:0]     b_resp, slot_idx;
  logic [7:0]     aw_len;
  logic           aw_valid, w_last, w_valid, b_ready, pc_busy, pc_done, pc_err;
  logic [255:0]   w_data;
  logic [2:0]     dbg_state;
  logic [255:0]   exp_q[$];

  // Narrow instance
  logic           q_start, q_clear, q_aw_ready, q_w_ready, q_b_valid;
  logic [319:0]   q_counters;
  logic [63:0]    q_base, q_aw_addr;
  logic [1:0]     q_resp, q_slot;
  logic [7:0]     q_aw_len;
  logic           q_aw_valid, q_w_last, q_w_valid, q_b_ready, q_busy, q_done, q_err;
  logic [127:0]   q_w_data;
  logic [2:0]     q_dbg;
  logic [127:0]   exp_q_b[$];

  perf_counter_dump_engine u_dut (
    .clk(clk), .reset(reset), .pc_start(pc_start), .pc_counters(pc_counters),
    .base_addr(base_addr), .slot_clear(slot_clear),
    .axi_aw_addr(aw_addr), .axi_aw_len(aw_len), .axi_aw_valid(aw_valid), .axi_aw_ready(aw_ready),
    .axi_w_data(w_data), .axi_w_last(w_last), .axi_w_valid(w_valid), .axi_w_ready(w_ready),
    .axi_b_valid(b_valid), .axi_b_resp(b_resp), .axi_b_ready(b_ready),
    .pc_busy(pc_busy), .pc_done(pc_done), .pc_err(pc_err), .slot_idx(slot_idx),
    .o_dbg_state(dbg_state)
  );

  perf_counter_dump_engine #(.AXI_DATA_WIDTH(128), .NUM_COUNTERS(5)) u_dut_b (
    .clk(clk), .reset(reset), .pc_start(q_start), .pc_counters(q_counters),
    .base_addr(q_base), .slot_clear(q_clear),
    .axi_aw_addr(q_aw_addr), .axi_aw_len(q_aw_len), .axi_aw_valid(q_aw_valid), .axi_aw_ready(q_aw_ready),
    .axi_w_data(q_w_data), .axi_w_last(q_w_last), .axi_w_valid(q_w_valid), .axi_w_ready(q_w_ready),
    .axi_b_valid(q_b_valid), .axi_b_resp(q_resp), .axi_b_ready(q_b_ready),
    .pc_busy(q_busy), .pc_done(q_done), .pc_err(q_err), .slot_idx(q_slot),
    .o_dbg_state(q_dbg)
  );

  // One full dump on the default instance. Expected beats are pushed before
  // start; each accepted beat pops and compares. aw_dly/b_dly are stall
  // cycles before ready/bvalid; w_tog alternates w_ready starting low; poke
  // overwrites the counters during W and raises pc_start during B.
  task automatic do_dump(input int aw_dly, input bit w_tog, input int b_dly, input bit clr,
                         input bit poke, output logic [63:0] obs_addr, output int done_cyc,
                         output int busy_cyc);
    logic [255:0] beat, held;
    logic [63:0]  exp_addr;
    logic         held_last, stalled, tog, second_aw;
    int cyc, aw_cnt, b_cnt, nbeat, done_cnt, post;
    for (int b = 0; b < 6; b++) begin
      beat = '0;
      for (int l = 0; l < 4; l++) beat[l*64 +: 64] = pc_counters[(b*4+l)*64 +: 64];
      exp_q.push_back(beat);
    end
    if (clr) m_slot = 0;
    exp_addr = base_addr + 64'(m_slot * 192);
    obs_addr = '0; done_cyc = 0; busy_cyc = 0; cyc = 0; aw_cnt = 0; b_cnt = 0;
    nbeat = 0; done_cnt = 0; post = 0; stalled = 0; tog = 0; second_aw = 0;
    held = '0; held_last = 0;
    @(negedge clk); pc_start = 1; slot_clear = clr;
    @(negedge clk); pc_start = 0; slot_clear = 0;
    while (cyc < 300 && post < 4) begin
      cyc++;
      if (pc_busy) busy_cyc++;
      if (pc_done) begin done_cnt++; done_cyc = cyc; end
      if (done_cnt > 0) post++;
      if (aw_valid && done_cnt > 0) second_aw = 1;
      if (aw_valid) begin
        if (aw_cnt == 0) obs_addr = aw_addr;
        else begin
          vectors++;
          if (aw_addr !== obs_addr) begin
            miscompares++; $display("FAIL aw_addr_stall: got %h expected %h", aw_addr, obs_addr);
          end
        end
        aw_ready = (aw_cnt >= aw_dly); aw_cnt++;
      end else aw_ready = 0;
      if (w_valid) begin
        if (stalled) begin
          vectors++;
          if ({w_last, w_data} !== {held_last, held}) begin
            miscompares++; $display("FAIL w_stall: got %h/%b expected %h/%b", w_data, w_last, held, held_last);
          end
        end
        w_ready = w_tog ? tog : 1'b1; tog = ~tog;
        if (w_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++; $display("FAIL w_beat_extra: got %h expected none", w_data);
          end else begin
            beat = exp_q.pop_front();
            if (w_data !== beat) begin
              miscompares++; $display("FAIL w_beat%0d: got %h expected %h", nbeat, w_data, beat);
            end
          end
          vectors++;
          if (w_last !== (nbeat == 5)) begin
            miscompares++; $display("FAIL w_last%0d: got %b expected %b", nbeat, w_last, nbeat == 5);
          end
          nbeat++; stalled = 0;
        end else begin
          stalled = 1; held = w_data; held_last = w_last;
        end
        if (poke && nbeat >= 2) pc_counters = '1;
      end else w_ready = 0;
      if (b_ready) begin
        b_valid = (b_cnt >= b_dly); b_resp = 2'b00; b_cnt++;
        if (poke) pc_start = 1;
      end else begin
        b_valid = 0; pc_start = 0;
      end
      @(negedge clk);
    end
    aw_ready = 0; w_ready = 0; b_valid = 0; pc_start = 0;
    m_slot = (m_slot + 1) % 4;
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++; $display("FAIL done_count: got %0d expected 1", done_cnt);
    end
    vectors++;
    if (nbeat !== 6 || exp_q.size() !== 0) begin
      miscompares++; $display("FAIL beat_count: got %0d left %0d expected 6 left 0", nbeat, exp_q.size());
    end
    exp_q.delete();
    vectors++;
    if (second_aw) begin
      miscompares++; $display("FAIL second_burst: got aw_valid after done expected none");
    end
    vectors++;
    if (obs_addr !== exp_addr) begin
      miscompares++; $display("FAIL aw_addr: got %h expected %h", obs_addr, exp_addr);
    end
    vectors++;
    if (aw_len !== 8'd5) begin
      miscompares++; $display("FAIL aw_len: got %0d expected 5", aw_len);
    end
    vectors++;
    if (slot_idx !== 2'(m_slot)) begin
      miscompares++; $display("FAIL slot_idx: got %0d expected %0d", slot_idx, m_slot);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({aw_valid, w_valid, w_last, b_ready, pc_busy, pc_done, pc_err} !== 7'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b expected 0000000",
                              {aw_valid, w_valid, w_last, b_ready, pc_busy, pc_done, pc_err});
    end
    vectors++;
    if ({slot_idx, dbg_state} !== 5'b0) begin
      miscompares++; $display("FAIL reset_slot_state: got %0d/%0d expected 0/0", slot_idx, dbg_state);
    end
    vectors++;
    if (aw_addr !== 64'h0 || w_data !== 256'h0) begin
      miscompares++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", aw_addr, w_data);
    end
    vectors++;
    if (aw_len !== 8'd5) begin
      miscompares++; $display("FAIL reset_aw_len: got %0d expected 5", aw_len);
    end
    vectors++;
    if ({q_aw_valid, q_w_valid, q_w_last, q_b_ready, q_busy, q_done, q_err, q_slot, q_dbg} !== 12'b0
        || q_aw_addr !== 64'h0 || q_w_data !== 128'h0 || q_aw_len !== 8'd2) begin
      miscompares++; $display("FAIL reset_narrow: got len %0d addr %h expected len 2 addr 0", q_aw_len, q_aw_addr);
    end
    reset = 0;
    m_slot = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [63:0] a;
    int dc, bc;
    for (int k = 0; k < 24; k++) pc_counters[k*64 +: 64] = 64'(4096 + k);
    do_dump(0, 0, 0, 0, 0, a, dc, bc);
    vectors++;
    if (a !== 64'h8000_0000) begin
      miscompares++; $display("FAIL basic_addr: got %h expected 80000000", a);
    end
    vectors++;
    if (dc !== 9) begin
      miscompares++; $display("FAIL basic_latency: got %0d expected 9", dc);
    end
    vectors++;
    if (bc !== 9) begin
      miscompares++; $display("FAIL basic_busy: got %0d expected 9", bc);
    end
  endtask

  task automatic test_ring_wrap();
    int offs[5] = '{0, 192, 384, 576, 0};
    int slots[5] = '{1, 2, 3, 0, 1};
    logic [63:0] a;
    int dc, bc;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 24; k++) pc_counters[k*64 +: 64] = {$urandom, $urandom};
      do_dump(0, 0, 0, i == 0, 0, a, dc, bc);
      vectors++;
      if (a !== 64'h8000_0000 + 64'(offs[i])) begin
        miscompares++; $display("FAIL ring_addr%0d: got %h expected base+%0d", i, a, offs[i]);
      end
      vectors++;
      if (slot_idx !== 2'(slots[i])) begin
        miscompares++; $display("FAIL ring_slot%0d: got %0d expected %0d", i, slot_idx, slots[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a;
    int dc, bc;
    for (int k = 0; k < 24; k++) pc_counters[k*64 +: 64] = {$urandom, $urandom};
    do_dump(3, 1, 4, 0, 0, a, dc, bc);
    // AW cycles 1-4, W cycles 5-16 (beats on even cycles), B 17-21, DONE 22
    vectors++;
    if (dc !== 22) begin
      miscompares++; $display("FAIL bp_latency: got %0d expected 22", dc);
    end
  endtask

  task automatic test_snapshot();
    logic [63:0] a;
    int dc, bc;
    for (int k = 0; k < 24; k++) pc_counters[k*64 +: 64] = {$urandom, $urandom};
    do_dump(0, 0, 0, 0, 1, a, dc, bc);
    vectors++;
    if (pc_busy !== 1'b0) begin
      miscompares++; $display("FAIL snap_idle: got busy %b expected 0", pc_busy);
    end
  endtask

  task automatic test_reset_clear();
    logic [63:0] a;
    int dc, bc, bad;
    for (int k = 0; k < 24; k++) pc_counters[k*64 +: 64] = {$urandom, $urandom};
    aw_ready = 1; w_ready = 1;
    @(negedge clk); pc_start = 1;
    @(negedge clk); pc_start = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if (w_valid !== 1'b1) begin
      miscompares++; $display("FAIL rst_in_w: got w_valid %b expected 1", w_valid);
    end
    reset = 1;
    @(negedge clk);
    reset = 0; aw_ready = 0; w_ready = 0;
    vectors++;
    if ({aw_valid, w_valid, w_last, b_ready, pc_busy, pc_done, pc_err, dbg_state} !== 10'b0) begin
      miscompares++; $display("FAIL rst_mid_ctrl: got %b expected 0",
                              {aw_valid, w_valid, w_last, b_ready, pc_busy, pc_done, pc_err, dbg_state});
    end
    vectors++;
    if (slot_idx !== 2'd0 || aw_addr !== 64'h0 || w_data !== 256'h0) begin
      miscompares++; $display("FAIL rst_mid_data: got slot %0d addr %h expected 0/0", slot_idx, aw_addr);
    end
    m_slot = 0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (pc_done || pc_busy) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++; $display("FAIL rst_no_done: got %0d active cycles expected 0", bad);
    end
    do_dump(0, 0, 0, 0, 0, a, dc, bc);
    do_dump(0, 0, 0, 1, 0, a, dc, bc);
    vectors++;
    if (a !== 64'h8000_0000 || slot_idx !== 2'd1) begin
      miscompares++; $display("FAIL clear_start: got %h slot %0d expected 80000000 slot 1", a, slot_idx);
    end
  endtask

  task automatic test_err_partial();
    logic [127:0] beat, got2;
    int nb, dn, cyc;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 5; k++) q_counters[k*64 +: 64] = {$urandom, $urandom};
      for (int b = 0; b < 3; b++) begin
        beat = '0;
        for (int l = 0; l < 2; l++)
          if (b*2 + l < 5) beat[l*64 +: 64] = q_counters[(b*2+l)*64 +: 64];
        exp_q_b.push_back(beat);
      end
      q_resp = (pass == 0) ? 2'b10 : 2'b00;
      q_aw_ready = 1; q_w_ready = 1; q_b_valid = 1;
      @(negedge clk); q_start = 1;
      @(negedge clk); q_start = 0;
      nb = 0; dn = 0; cyc = 0; got2 = '1;
      while (cyc < 50 && dn == 0) begin
        cyc++;
        if (q_aw_valid) begin
          vectors++;
          if (q_aw_addr !== 64'h1000_0000 + 64'(pass * 48) || q_aw_len !== 8'd2) begin
            miscompares++; $display("FAIL q_aw: got %h len %0d expected base+%0d len 2", q_aw_addr, q_aw_len, pass*48);
          end
        end
        if (q_w_valid) begin
          vectors++;
          if (exp_q_b.size() == 0) begin
            miscompares++; $display("FAIL q_beat_extra: got %h expected none", q_w_data);
          end else begin
            beat = exp_q_b.pop_front();
            if (q_w_data !== beat) begin
              miscompares++; $display("FAIL q_beat%0d: got %h expected %h", nb, q_w_data, beat);
            end
          end
          vectors++;
          if (q_w_last !== (nb == 2)) begin
            miscompares++; $display("FAIL q_last%0d: got %b expected %b", nb, q_w_last, nb == 2);
          end
          if (nb == 2) got2 = q_w_data;
          nb++;
        end
        if (q_done) dn = 1;
        @(negedge clk);
      end
      vectors++;
      if (dn !== 1 || nb !== 3) begin
        miscompares++; $display("FAIL q_done: got done %0d beats %0d expected 1/3", dn, nb);
      end
      exp_q_b.delete();
      vectors++;
      if (got2[127:64] !== 64'h0) begin
        miscompares++; $display("FAIL q_pad_lane: got %h expected 0", got2[127:64]);
      end
      vectors++;
      if (q_err !== 1'b1) begin
        miscompares++; $display("FAIL q_err_pass%0d: got %b expected 1", pass, q_err);
      end
    end
    q_aw_ready = 0; q_w_ready = 0; q_b_valid = 0;
  endtask

  initial begin
    reset = 1;
    pc_start = 0; slot_clear = 0; aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 2'b00;
    pc_counters = '0; base_addr = 64'h8000_0000;
    q_start = 0; q_clear = 0; q_aw_ready = 0; q_w_ready = 0; q_b_valid = 0; q_resp = 2'b00;
    q_counters = '0; q_base = 64'h1000_0000;
    test_reset();
    test_basic();
    test_ring_wrap();
    test_backpressure();
    test_snapshot();
    test_reset_clear();
    test_err_partial();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/perf_counter_dump_engine.md
# perf_counter_dump_engine

Parametrised performance-counter dump engine for the GeneSys accelerator. It snapshots an arbitrary number of 64-bit counters on a start request and packs them into full-width AXI write beats. It then issues one fully handshaked AXI burst into a ring of DDR slots and reports completion. It sits between the controller/buffer counter sources and the AXI write master, and replaces the fixed six-packet dumper.

## Interface
- PC_DATA_WIDTH, 64, width of one counter
- AXI_DATA_WIDTH, 256, AXI write-data width; must be a multiple of PC_DATA_WIDTH
- AXI_ADDR_WIDTH, 64, AXI address width
- NUM_COUNTERS, 24, counters captured per dump (1..256)
- NUM_SLOTS, 4, DDR ring depth in dump records (power of two, 1..16)
- Derived: CPB = AXI_DATA_WIDTH/PC_DATA_WIDTH; BEATS = ceil(NUM_COUNTERS/CPB), at most 256; STRIDE = BEATS*AXI_DATA_WIDTH/8 bytes

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- pc_start  in  1  dump request
- pc_counters  in  NUM_COUNTERS*PC_DATA_WIDTH  flat counter vector; counter k at [k*PC_DATA_WIDTH +: PC_DATA_WIDTH]
- base_addr  in  AXI_ADDR_WIDTH  DDR address of slot 0
- slot_clear  in  1  resets the ring index to 0 (IDLE only)
- axi_aw_addr  out  AXI_ADDR_WIDTH  burst address
- axi_aw_len  out  8  BEATS-1
- axi_aw_valid  out  1  address valid
- axi_aw_ready  in  1  address accepted
- axi_w_data  out  AXI_DATA_WIDTH  beat data
- axi_w_last  out  1  final beat
- axi_w_valid  out  1  data valid
- axi_w_ready  in  1  data accepted
- axi_b_valid  in  1  write response valid
- axi_b_resp  in  2  write response code
- axi_b_ready  out  1  response accept
- pc_busy  out  1  high from start acceptance through DONE
- pc_done  out  1  one-cycle completion pulse
- pc_err  out  1  sticky: set if any bresp != 0
- slot_idx  out  $clog2(NUM_SLOTS) (min 1)  slot used by the next dump

## Operation
- States: IDLE, AW, W, B, DONE.
- IDLE:
  - pc_start=1 captures pc_counters into the snapshot register.
  - axi_aw_addr is latched as base_addr + slot_idx*STRIDE, computed modulo 2^AXI_ADDR_WIDTH.
  - The beat counter is cleared and the FSM moves to AW.
- AW: axi_aw_valid=1. On axi_aw_ready, go to W.
- W:
  - axi_w_valid=1. axi_w_data = beat[beat_cnt].
  - axi_w_last=1 when beat_cnt == BEATS-1.
  - On axi_w_ready, beat_cnt increments. The last accepted beat moves the FSM to B.
- B: axi_b_ready=1. On axi_b_valid, pc_err |= (axi_b_resp != 0), then go to DONE.
- DONE:
  - pc_done=1 for one cycle.
  - slot_idx increments; it wraps from NUM_SLOTS-1 to 0.
  - FSM returns to IDLE.
- Packing: counter k is placed in beat k/CPB, bits [(k%CPB)*PC_DATA_WIDTH +: PC_DATA_WIDTH]. Unused lanes of the last beat are zero.
- Data comes from the snapshot only. Changes on pc_counters after capture never appear in the dump.
- pc_start outside IDLE is ignored; requests are not queued.
- slot_clear in IDLE sets slot_idx to 0. If it coincides with pc_start, the clear takes effect first, so the dump goes to slot 0. slot_clear outside IDLE is ignored.
- valid/data/last stay stable while valid=1 and ready=0.

## Timing
- Reset values:
  - FSM = IDLE; slot_idx = 0; pc_err = 0; pc_busy = 0; pc_done = 0.
  - All AXI valid/ready/last outputs = 0; axi_aw_addr = 0; axi_w_data = 0.
  - axi_aw_len is the constant BEATS-1.
- Reset mid-operation: the FSM aborts immediately to IDLE with the outputs above. No pc_done is generated; the partial burst is abandoned and the AXI fabric is reset alongside.
- Start accepted at edge t: axi_aw_valid is high in cycle t+1.
- Latency with all readies tied high and bvalid in the first B cycle: start edge to pc_done high = BEATS+3 cycles. pc_busy is high for the same span.
- With always-ready handshakes, one beat is transferred per cycle; there are no bubbles between beats.
- The next pc_start is accepted at the earliest in the cycle after DONE.
- All outputs are registered or decoded from the registered state; there is no combinational path from an AXI ready input to a valid output.

## Test plan
- Defaults, readies=1:
  - Stimulus: counter k = 0x1000+k; pulse pc_start.
  - Required response: AW addr = base_addr (0x8000_0000), len = 5.
  - Six beats; beat0 lanes = 0x1000..0x1003 (LSB first); last asserted only on beat 5.
  - pc_done exactly 9 cycles after the start edge.
- Ring wrap:
  - Stimulus: five back-to-back dumps.
  - Required response: addresses base+0, +192, +384, +576, then base+0 again; slot_idx reads 1,2,3,0,1 after each done.
- Backpressure:
  - Stimulus: aw_ready held low for 3 cycles; w_ready toggled 1/0 each cycle; bvalid delayed 4 cycles.
  - Required response: data held stable under stall; all 6 beats in order; exactly one pc_done.
- Snapshot and ignore:
  - Stimulus: change all counters to 0xFFFF... during W; issue pc_start during B.
  - Required response: captured values are written; no second burst.
- Error/partial:
  - Stimulus: NUM_COUNTERS=5, AXI_DATA_WIDTH=128 (BEATS=3, lane-1 of beat 2 zero); bresp=2'b10.
  - Required response: pc_err=1 and it stays set through a following clean dump.
- Reset and clear:
  - Stimulus: reset asserted mid-W, then slot_clear together with pc_start.
  - Required response: all outputs at reset values next cycle; no done pulse; the new dump goes to slot 0.
